// File: rtl/load_store_unit.sv
// Load/store initiator between the pipeline and a word-addressed data-memory bus.
// It runs one access at a time under a req/ack handshake and stalls the pipeline while that access is outstanding.
module load_store_unit #(
  parameter int data_width = 32,
  parameter int addr_width = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  lsu_req,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] store_data,
  output logic                  stall,
  output logic [data_width-1:0] load_data,
  output logic                  load_valid,
  output logic                  lsu_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [data_width-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state, state_nxt;
  logic       accept, reject;
  logic [1:0] lo_p1;
  logic [2:0] f3_p1;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b10:   return lo == 2'b00;
      2'b01:   return !lo[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [data_width-1:0] store_lanes(input logic [2:0] f3,
                                                        input logic [data_width-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [data_width-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [1:0] lo,
                                                        input logic [data_width-1:0] rd);
    logic        [data_width-1:0] sh;
    logic signed [7:0]            b;
    logic signed [15:0]           h;
    logic signed [data_width-1:0] res;
    sh = rd >> {lo, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  res = b;
      3'b001:  res = h;
      3'b100:  res = {{(data_width-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(data_width-16){1'b0}}, sh[15:0]};
      default: res = rd;
    endcase
    return res;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    reject     = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    load_valid = 1'b0;
    case (state)
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) state_nxt = RESP;
      end
      default: begin
        load_valid = (state == RESP) && !mem_we;
        accept     = lsu_req && is_legal(is_store, funct3) && is_aligned(funct3, addr[1:0]);
        reject     = lsu_req && !accept;
        stall      = accept;
        state_nxt  = accept ? BUSY : IDLE;
      end
    endcase
  end

  // Stage p1: bus registers and captured lane info for the accepted access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      lo_p1     <= 2'b00;
      f3_p1     <= 3'b000;
      lsu_error <= 1'b0;
    end else begin
      lsu_error <= reject;
      if (accept) begin
        mem_we    <= is_store;
        mem_addr  <= {addr[addr_width-1:2], 2'b00};
        mem_wdata <= is_store ? store_lanes(funct3, store_data) : '0;
        mem_wstrb <= is_store ? store_strb(funct3, addr[1:0]) : 4'b0000;
        lo_p1     <= addr[1:0];
        f3_p1     <= funct3;
      end
    end
  end

  // Stage p2: load result captured on the acknowledge
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      load_data <= '0;
    else if (state == BUSY && mem_ack && !mem_we)
      load_data <= load_extend(f3_p1, lo_p1, mem_rdata);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator for the execute/writeback boundary of the 3-stage RISC-V pipeline. Accepts one load or store per request from the pipeline and drives a word-addressed data-memory bus with a request/acknowledge handshake. Stalls the pipeline while the access is outstanding. Returns sign- or zero-extended load data, or byte-lane-aligned store data with write strobes.

## Interface
Parameters:
- data_width, 32, data bus and register width (only 32 supported)
- addr_width, 32, byte address width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- lsu_req  in  1  pipeline requests an access this cycle
- is_store  in  1  1 = store, 0 = load; sampled with lsu_req
- funct3  in  3  RV32I width/sign code; sampled with lsu_req
- addr  in  addr_width  byte address; sampled with lsu_req
- store_data  in  data_width  rs2 value; sampled with lsu_req
- stall  out  1  hold the pipeline
- load_data  out  data_width  extended load result
- load_valid  out  1  load_data valid (1-cycle pulse)
- lsu_error  out  1  misaligned or illegal funct3 (1-cycle pulse)
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  addr_width  word address, bits [1:0] forced to 0
- mem_wdata  out  data_width  lane-aligned write data
- mem_wstrb  out  4  byte write strobes (0 for loads)
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  data_width  read word, valid with mem_ack

## Operation
- Uses a three-state FSM: IDLE, BUSY, RESP.
- IDLE/RESP behaviour:
  - lsu_req with legal funct3 and aligned address is accepted. Bus registers are loaded, address bits [1:0] and funct3 are captured, and the FSM moves to BUSY.
  - lsu_req with an illegal or misaligned access pulses lsu_error next cycle. No bus access is made. The FSM goes to IDLE.
  - With no lsu_req, the FSM goes to IDLE.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store values: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Alignment: word accesses need addr[1:0]=00. Half accesses need addr[0]=0. Byte accesses are always aligned.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0]; wdata = store_data[7:0] replicated ×4.
  - SH: wstrb = 0011<<addr[1:0]; wdata = store_data[15:0] replicated ×2.
  - SW: wstrb = 1111; wdata = store_data.
- BUSY: mem_req=1 and all bus outputs are held stable until mem_ack. On mem_ack the FSM moves to RESP. For a load, load_data is registered from mem_rdata: select byte/half by the captured addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- RESP: load_valid=1 for loads only, with stall=0. load_data holds its value until the next load completes.
- mem_ack outside BUSY is ignored.

## Timing
- Reset values: stall=0, load_data=0, load_valid=0, lsu_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0. FSM = IDLE.
- An asserted reset during BUSY drops mem_req immediately (asynchronous). The access is abandoned and no response is produced.
- stall = (state==BUSY) OR (lsu_req AND legal AND aligned AND state≠BUSY). stall is combinational, so it is high in the acceptance cycle.
- Latency, with request accepted at cycle T:
  - mem_req is first high at T+1.
  - Earliest mem_ack is at T+1.
  - load_valid is at (ack cycle)+1.
  - Minimum load-to-data latency is 2 cycles. Each wait state adds 1 cycle.
- lsu_error is asserted at T+1 and lasts exactly 1 cycle.
- A request in the RESP cycle is accepted (back-to-back). mem_req then re-asserts in the cycle after RESP, giving one idle bus cycle between accesses.
- Pipeline inputs are ignored during BUSY.

## Test plan
- Zero-wait store then load:
  - SW addr=0x100, data=0xDEADBEEF, ack at T+1 → mem_addr=0x100, wstrb=1111, mem_we=1; stall high T..T+1.
  - LW 0x100 with rdata=0xDEADBEEF → load_valid at T+2, load_data=0xDEADBEEF.
- Byte/half extension with rdata=0x80FF7F01:
  - LB addr 0x103 → 0xFFFFFF80.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF80FF.
  - LHU 0x100 → 0x00007F01.
- Store lanes:
  - SB addr 0x202, data 0x12345678 → wstrb=0100, wdata=0x78787878, mem_addr=0x200.
  - SH 0x202 → wstrb=1100, wdata=0x56785678.
- Errors:
  - LW 0x101, SH 0x103, and funct3=011 → lsu_error pulse at T+1, mem_req never asserts, stall stays 0.
- Wait states and reset:
  - LW with mem_ack delayed 5 cycles → mem_req and mem_addr stable for all 5 cycles, stall high throughout, load_valid 1 cycle after ack.
  - Repeat with reset asserted mid-BUSY → mem_req=0 immediately, load_valid never pulses, FSM=IDLE.
- Back-to-back:
  - LW accepted, then SW presented in the RESP cycle → SW accepted and second mem_req appears the cycle after RESP.
  - Stray mem_ack in IDLE → no output change.
